// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned ZERO_REG     = 0;

    // Width able to hold a count of 0..num_regs pending registers.
    function automatic int unsigned pend_cnt_w(input int unsigned num_regs);
        return $clog2(num_regs + 1);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: array select, write-to-read forwarding and pending-bit lookup.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0]               raddr,
    input  logic [NUM_REGS-1:0][XLEN-1:0]   mem,
    input  logic [NUM_REGS-1:0]             pend,
    input  logic                            wr0,
    input  logic [ADDR_W-1:0]               waddr0,
    input  logic [XLEN-1:0]                 wdata0,
    input  logic                            wr1,
    input  logic [ADDR_W-1:0]               waddr1,
    input  logic [XLEN-1:0]                 wdata1,
    output logic [XLEN-1:0]                 rdata,
    output logic                            rbusy
);

    logic is_zero;

    assign is_zero = (raddr == ADDR_W'(ZERO_REG));

    // wr0/wr1 arrive already qualified against reset and x0 by the top.
    always_comb begin
        rdata = mem[raddr];
        rbusy = pend[raddr];
        if (BYPASS) begin
            if (wr1 && (waddr1 == raddr)) begin
                rdata = wdata1;
                rbusy = 1'b0;
            end else if (wr0 && (waddr0 == raddr)) begin
                rdata = wdata0;
                rbusy = 1'b0;
            end
        end
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two write ports, NUM_READ read ports, per-register pending bits.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_READ = 2,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_READ*ADDR_W-1:0]        raddr,
    output logic [NUM_READ*XLEN-1:0]          rdata,
    output logic [NUM_READ-1:0]               rbusy,
    input  logic                              we0,
    input  logic [ADDR_W-1:0]                 waddr0,
    input  logic [XLEN-1:0]                   wdata0,
    input  logic                              we1,
    input  logic [ADDR_W-1:0]                 waddr1,
    input  logic [XLEN-1:0]                   wdata1,
    input  logic                              pset,
    input  logic [ADDR_W-1:0]                 paddr,
    output logic [pend_cnt_w(NUM_REGS)-1:0]   pend_cnt
);

    localparam int unsigned CNT_W = pend_cnt_w(NUM_REGS);

    logic [NUM_REGS-1:0][XLEN-1:0] mem_q, mem_d;
    logic [NUM_REGS-1:0]           pend_q, pend_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]              set_n, clr_n;
    logic                          wr0, wr1, ps;

    assign wr0 = we0  && !reset && (waddr0 != ADDR_W'(ZERO_REG));
    assign wr1 = we1  && !reset && (waddr1 != ADDR_W'(ZERO_REG));
    assign ps  = pset && !reset && (paddr  != ADDR_W'(ZERO_REG));

    // Port 1 is applied last so it wins a collision; the set is applied after both clears.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr0) begin
            mem_d[waddr0]  = wdata0;
            pend_d[waddr0] = 1'b0;
        end
        if (wr1) begin
            mem_d[waddr1]  = wdata1;
            pend_d[waddr1] = 1'b0;
        end
        if (ps) begin
            pend_d[paddr] = 1'b1;
        end
    end

    // Only bits that actually change move the count.
    always_comb begin
        set_n = '0;
        clr_n = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            set_n = set_n + CNT_W'(pend_d[i] & ~pend_q[i]);
            clr_n = clr_n + CNT_W'(pend_q[i] & ~pend_d[i]);
        end
        cnt_d = cnt_q + set_n - clr_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        regfile_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS)
        ) u_rd (
            .raddr  (raddr[k*ADDR_W +: ADDR_W]),
            .mem    (mem_q),
            .pend   (pend_q),
            .wr0    (wr0),
            .waddr0 (waddr0),
            .wdata0 (wdata0),
            .wr1    (wr1),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
            .rdata  (rdata[k*XLEN +: XLEN]),
            .rbusy  (rbusy[k])
        );
    end

endmodule
